// File: rtl/onchip_mem_loader.sv
// Boot-loader front end: packs a byte stream little-endian into 32-bit words and writes them
// into the on-chip RAM Avalon slave, holding the CPU in reset while an image is loading.
module onchip_mem_loader #(
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  byte_count,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [3:0]            m_byteenable,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [31:0]           m_writedata,
  output logic                  busy,
  output logic                  done,
  output logic                  wrapped,
  output logic                  cpu_reset_hold
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] FINISH  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0]  rem;
  logic [1:0]            lane;
  logic [3:0]            be;
  logic [31:0]           data;
  logic                  wr;
  logic                  accept;
  logic [31:0]           data_ins;
  logic [3:0]            be_ins;

  assign s_ready      = (state == COLLECT);
  assign accept       = s_valid && s_ready;
  // Chipselect and write strobe come from a single flop so they can never disagree.
  assign m_chipselect = wr;
  assign m_write      = wr;

  // Word and lane mask including the byte being accepted this cycle.
  always_comb begin
    data_ins = data;
    data_ins[{lane, 3'b000} +: 8] = s_data;
    be_ins = be;
    be_ins[lane] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      addr           <= '0;
      rem            <= '0;
      lane           <= '0;
      be             <= '0;
      data           <= '0;
      wr             <= 1'b0;
      m_address      <= '0;
      m_byteenable   <= '0;
      m_writedata    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      wrapped        <= 1'b0;
      cpu_reset_hold <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wrapped <= 1'b0;
            if (byte_count != '0) begin
              addr           <= base_addr;
              rem            <= byte_count;
              lane           <= '0;
              be             <= '0;
              data           <= '0;
              busy           <= 1'b1;
              cpu_reset_hold <= 1'b1;
              state          <= COLLECT;
            end else begin
              done           <= 1'b1;
              cpu_reset_hold <= 1'b0;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            data <= data_ins;
            be   <= be_ins;
            rem  <= rem - CNT_WIDTH'(1);
            lane <= lane + 2'd1;
            // Word full or image exhausted: present the word on the next cycle.
            if (lane == 2'd3 || rem == CNT_WIDTH'(1)) begin
              wr           <= 1'b1;
              m_address    <= addr;
              m_byteenable <= be_ins;
              m_writedata  <= data_ins;
              state        <= WRITE;
            end
          end
        end
        WRITE: begin
          wr   <= 1'b0;
          addr <= addr + ADDR_WIDTH'(1);
          if ((&addr) && rem != '0) wrapped <= 1'b1;
          lane <= '0;
          be   <= '0;
          data <= '0;
          if (rem == '0) begin
            done           <= 1'b1;
            busy           <= 1'b0;
            cpu_reset_hold <= 1'b0;
            state          <= FINISH;
          end else begin
            state <= COLLECT;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_loader.sv
// Self-checking bench for onchip_mem_loader: a transaction-level model predicts every output
// on each cycle, and literal expectations pin the model on the hand-computed cases.
module tb_onchip_mem_loader;
  localparam int AW = 11;
  localparam int CW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] byte_count = '0;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [AW-1:0] m_address;
  logic [3:0]    m_byteenable;
  logic          m_chipselect;
  logic          m_write;
  logic [31:0]   m_writedata;
  logic          busy;
  logic          done;
  logic          wrapped;
  logic          cpu_reset_hold;

  onchip_mem_loader #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .byte_count     (byte_count),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .m_address      (m_address),
    .m_byteenable   (m_byteenable),
    .m_chipselect   (m_chipselect),
    .m_write        (m_write),
    .m_writedata    (m_writedata),
    .busy           (busy),
    .done           (done),
    .wrapped        (wrapped),
    .cpu_reset_hold (cpu_reset_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Behavioural model: which load is active, how many bytes taken, and what write is due.
  bit          md_loading, md_wr_now, md_done_now, md_done_load, md_hold, md_wrapped;
  int          md_n, md_idx, md_lane;
  logic [AW-1:0] md_base, md_waddr;
  logic [31:0] md_word;
  logic [3:0]  md_be;
  bit          exp_sr, acc, nxt_wr, nxt_done, start_ok;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  logic [3:0]    log_be[$];
  int            first_acc_cyc, done_cyc;

  always @(negedge clk) begin
    if (reset) begin
      md_loading = 0; md_wr_now = 0; md_done_now = 0; md_done_load = 0;
      md_hold = 1; md_wrapped = 0;
      check("reset_flags", {s_ready, m_write, m_chipselect, busy, done, wrapped, cpu_reset_hold},
            7'b0000001);
      check("reset_bus", {m_address, m_byteenable, m_writedata}, '0);
    end else begin
      exp_sr = md_loading && !md_wr_now;
      check("s_ready", s_ready, exp_sr);
      check("m_write", m_write, md_wr_now);
      check("m_chipselect", m_chipselect, md_wr_now);
      check("busy", busy, md_loading);
      check("done", done, md_done_now);
      check("cpu_reset_hold", cpu_reset_hold, md_hold);
      check("wrapped", wrapped, md_wrapped);
      if (md_wr_now) begin
        check("m_address", m_address, md_waddr);
        check("m_byteenable", m_byteenable, md_be);
        check("m_writedata", m_writedata, md_word);
      end
      if (m_write) begin
        log_addr.push_back(m_address);
        log_data.push_back(m_writedata);
        log_be.push_back(m_byteenable);
      end
      if (done) done_cyc = cyc;

      start_ok = start && !md_loading && !md_done_load;
      acc = s_valid && exp_sr;
      nxt_wr = 0;
      nxt_done = 0;
      if (md_wr_now) begin
        if (md_waddr == '1 && md_idx != md_n) md_wrapped = 1;
        if (md_idx == md_n) begin
          nxt_done = 1; md_loading = 0; md_hold = 0;
        end
        md_word = '0;
        md_be = '0;
      end
      md_done_load = nxt_done;
      if (start_ok) begin
        md_wrapped = 0;
        if (byte_count == '0) begin
          nxt_done = 1; md_hold = 0;
        end else begin
          md_loading = 1; md_hold = 1; md_n = int'(byte_count); md_idx = 0;
          md_base = base_addr; md_word = '0; md_be = '0;
        end
      end
      if (acc) begin
        if (md_idx == 0) first_acc_cyc = cyc;
        md_lane = md_idx % 4;
        md_word[8*md_lane +: 8] = s_data;
        md_be[md_lane] = 1'b1;
        md_waddr = md_base + AW'(md_idx / 4);
        md_idx++;
        if (md_idx % 4 == 0 || md_idx == md_n) nxt_wr = 1;
      end
      md_wr_now = nxt_wr;
      md_done_now = nxt_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
    start = 1'b1; base_addr = b; byte_count = n;
    tick();
    start = 1'b0; base_addr = AW'($urandom); byte_count = CW'($urandom);
  endtask

  task automatic feed(input logic [7:0] bytes[$], input int gap_pct, input bit extra_starts);
    int ptr = 0;
    int budget = 40 * bytes.size() + 100;
    bit taken;
    while (ptr < bytes.size() && budget > 0) begin
      s_valid = ($urandom_range(0, 99) >= gap_pct);
      s_data = bytes[ptr];
      start = extra_starts && ($urandom_range(0, 7) == 0);
      base_addr = AW'($urandom);
      byte_count = CW'($urandom_range(0, 50));
      @(negedge clk);
      taken = s_valid && s_ready;
      tick();
      if (taken) ptr++;
      budget--;
    end
    s_valid = 1'b0; start = 1'b0; s_data = 8'($urandom);
    if (budget == 0) check("feed_timeout", ptr, bytes.size());
  endtask

  task automatic wait_done();
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        check("hold_at_done", cpu_reset_hold, 1'b0);
      end
    end
    check("done_seen", found, 1'b1);
    tick();
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); log_be.delete();
  endtask

  task automatic check_words(input logic [AW-1:0] a0, input logic [31:0] d0, input logic [3:0] b0,
                             input logic [AW-1:0] a1, input logic [31:0] d1, input logic [3:0] b1);
    check("write_count", log_addr.size(), 2);
    if (log_addr.size() >= 2) begin
      check("w0_addr", log_addr[0], a0); check("w0_data", log_data[0], d0);
      check("w0_be", log_be[0], b0);
      check("w1_addr", log_addr[1], a1); check("w1_data", log_data[1], d1);
      check("w1_be", log_be[1], b1);
    end
  endtask

  logic [7:0] q[$];
  logic [7:0] img_a[$];

  initial begin
    img_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Two full words, gap-free; done lands 10 cycles after the first accept.
    clear_log();
    do_start(AW'(11'h010), CW'(8));
    feed(img_a, 0, 0);
    wait_done();
    check_words(11'h010, 32'h44332211, 4'hF, 11'h011, 32'h88776655, 4'hF);
    check("done_latency", done_cyc - first_acc_cyc, 10);

    // Partial last word.
    clear_log();
    q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    do_start('0, CW'(6));
    feed(q, 0, 0);
    wait_done();
    check_words(11'h000, 32'hA3A2A1A0, 4'hF, 11'h001, 32'h0000A5A4, 4'h3);

    // Wrap past the top of memory; wrapped stays set until the next start.
    clear_log();
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_start(AW'(11'h7FF), CW'(8));
    feed(q, 0, 0);
    wait_done();
    check_words(11'h7FF, 32'h04030201, 4'hF, 11'h000, 32'h08070605, 4'hF);
    @(negedge clk);
    check("wrapped_sticky", wrapped, 1'b1);
    tick();
    do_start(AW'(11'h005), CW'(3));
    @(negedge clk);
    check("wrapped_cleared", wrapped, 1'b0);
    tick();
    q = '{8'hC0, 8'hC1, 8'hC2};
    feed(q, 0, 0);
    wait_done();

    // Zero-length load: done next cycle, no write, never busy.
    clear_log();
    do_start(AW'(11'h123), '0);
    @(negedge clk);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_hold", cpu_reset_hold, 1'b0);
    tick();
    @(negedge clk);
    check("zero_done_pulse", done, 1'b0);
    check("zero_no_write", log_addr.size(), 0);
    tick();

    // Reset two bytes into a load: aborts with no write issued.
    clear_log();
    do_start(AW'(11'h020), CW'(12));
    q = '{8'hE0, 8'hE1};
    feed(q, 0, 0);
    #1 reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("abort_no_write", log_addr.size(), 0);
    check("abort_idle", {s_ready, busy}, 2'b00);
    tick();

    // Same image with stalls and stray starts must produce the same writes.
    clear_log();
    do_start(AW'(11'h010), CW'(8));
    feed(img_a, 50, 1);
    wait_done();
    check_words(11'h010, 32'h44332211, 4'hF, 11'h011, 32'h88776655, 4'hF);

    // Random loads, checked against the model each cycle.
    for (int t = 0; t < 8; t++) begin
      int n = $urandom_range(1, 40);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      do_start(AW'($urandom), CW'(n));
      feed(q, $urandom_range(0, 60), 1);
      wait_done();
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
